// File: rtl/fft_input_stage.sv
// Ping-pong frame buffer that feeds MDC FFT stage 1 with (x[k], x[k+HALF]) pairs plus the twiddle index k.
// Optional macro FFT_IN_SOP_SYNC_EN adds in_sop, which restarts the frame being written at index 0.
module fft_input_stage #(
   parameter int WIDTH = 9,
   parameter int HALF  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
`ifdef FFT_IN_SOP_SYNC_EN
   input  logic                    in_sop,
`endif
   input  logic signed [WIDTH-1:0] in_re,
   input  logic signed [WIDTH-1:0] in_im,
   output logic                    out_valid,
   output logic                    out_sop,
   output logic                    out_eop,
   output logic signed [WIDTH-1:0] out_up_re,
   output logic signed [WIDTH-1:0] out_up_im,
   output logic signed [WIDTH-1:0] out_l_re,
   output logic signed [WIDTH-1:0] out_l_im,
   output logic [$clog2(HALF)-1:0] rom_16_counter
);

   localparam int IDXW = $clog2(HALF);
   localparam logic [IDXW:0]   FRAME_LAST = {(IDXW+1){1'b1}};
   localparam logic [IDXW-1:0] PAIR_FIRST = '0;
   localparam logic [IDXW-1:0] PAIR_LAST  = {IDXW{1'b1}};

   typedef enum logic {IDLE, READ} state_t;

   logic signed [WIDTH-1:0] r_memRe [4*HALF];
   logic signed [WIDTH-1:0] r_memIm [4*HALF];

   logic            r_wrBank;
   logic [IDXW:0]   r_wrCnt;
   logic [1:0]      r_bankFull;
   logic [IDXW:0]   w_wrIdx;
   logic            w_wrLast;
   logic [1:0]      w_setMask;
   logic [1:0]      w_clrMask;

   state_t          r_state;
   state_t          w_nextState;
   logic            r_rdBank;
   logic            w_nextRdBank;
   logic [IDXW-1:0] r_rdCnt;
   logic [IDXW-1:0] w_nextRdCnt;
   logic            w_emit;
   logic            w_clrFull;

`ifdef FFT_IN_SOP_SYNC_EN
   assign w_wrIdx = in_sop ? '0 : r_wrCnt;
`else
   assign w_wrIdx = r_wrCnt;
`endif
   assign w_wrLast  = in_valid && (w_wrIdx == FRAME_LAST);
   assign w_setMask = w_wrLast  ? (2'b01 << r_wrBank) : 2'b00;
   assign w_clrMask = w_clrFull ? (2'b01 << r_rdBank) : 2'b00;

   // Sample storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         r_memRe[{r_wrBank, w_wrIdx}] <= in_re;
         r_memIm[{r_wrBank, w_wrIdx}] <= in_im;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrBank   <= 1'b0;
         r_wrCnt    <= '0;
         r_bankFull <= 2'b00;
      end else begin
         if (in_valid) begin
            r_wrCnt <= w_wrIdx + 1'b1;
            if (w_wrLast)
               r_wrBank <= ~r_wrBank;
         end
         r_bankFull <= (r_bankFull & ~w_clrMask) | w_setMask;
      end
   end

   // IDLE emits pair 0 on the same edge it sees a full bank, so the first pair follows sample 31 by one clock.
   always_comb begin
      w_nextState  = r_state;
      w_nextRdCnt  = r_rdCnt;
      w_nextRdBank = r_rdBank;
      w_emit       = 1'b0;
      w_clrFull    = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_bankFull[r_rdBank]) begin
               w_emit      = 1'b1;
               w_nextState = READ;
            end
         end
         READ: begin
            w_emit = 1'b1;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
      if (w_emit) begin
         w_nextRdCnt = r_rdCnt + 1'b1;
         if (r_rdCnt == PAIR_LAST) begin
            w_clrFull    = 1'b1;
            w_nextRdBank = ~r_rdBank;
            w_nextState  = r_bankFull[~r_rdBank] ? READ : IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_rdBank <= 1'b0;
         r_rdCnt  <= '0;
      end else begin
         r_state  <= w_nextState;
         r_rdBank <= w_nextRdBank;
         r_rdCnt  <= w_nextRdCnt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid      <= 1'b0;
         out_sop        <= 1'b0;
         out_eop        <= 1'b0;
         out_up_re      <= '0;
         out_up_im      <= '0;
         out_l_re       <= '0;
         out_l_im       <= '0;
         rom_16_counter <= '0;
      end else if (w_emit) begin
         out_valid      <= 1'b1;
         out_sop        <= (r_rdCnt == PAIR_FIRST);
         out_eop        <= (r_rdCnt == PAIR_LAST);
         out_up_re      <= r_memRe[{r_rdBank, 1'b0, r_rdCnt}];
         out_up_im      <= r_memIm[{r_rdBank, 1'b0, r_rdCnt}];
         out_l_re       <= r_memRe[{r_rdBank, 1'b1, r_rdCnt}];
         out_l_im       <= r_memIm[{r_rdBank, 1'b1, r_rdCnt}];
         rom_16_counter <= r_rdCnt;
      end else begin
         out_valid      <= 1'b0;
         out_sop        <= 1'b0;
         out_eop        <= 1'b0;
         out_up_re      <= '0;
         out_up_im      <= '0;
         out_l_re       <= '0;
         out_l_im       <= '0;
         rom_16_counter <= '0;
      end
   end

   // The writer must never land on a bank the reader has not drained yet.
   assert property (@(posedge clk) disable iff (rst) !(in_valid && r_bankFull[r_wrBank]))
      else $error("fft_input_stage: write into a full bank");

endmodule

// File: tb/tb_fft_input_stage.sv
// Scoreboard bench for fft_input_stage: a frame-level model predicts every output pair and its cycle.
module tb_fft_input_stage;

   localparam int WIDTH = 9;
   localparam int HALF  = 16;

   typedef logic signed [WIDTH-1:0] sample_t;
   typedef struct {
      int      cyc;
      int      k;
      sample_t upRe;
      sample_t upIm;
      sample_t lRe;
      sample_t lIm;
   } pair_t;

   logic    clk = 1'b0;
   logic    rst = 1'b1;
   logic    inValid = 1'b0;
   logic    inSop = 1'b0;
   sample_t inRe = '0;
   sample_t inIm = '0;
   logic    outValid, outSop, outEop;
   sample_t outUpRe, outUpIm, outLRe, outLIm;
   logic [3:0] romCnt;

   int      checks = 0;
   int      errors = 0;
   int      edgeCnt = 0;
   int      nextFree = 0;
   pair_t   sbQ[$];
   sample_t frameRe[$];
   sample_t frameIm[$];
   pair_t   monExp;

   fft_input_stage #(.WIDTH(WIDTH), .HALF(HALF)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(inValid),
`ifdef FFT_IN_SOP_SYNC_EN
      .in_sop(inSop),
`endif
      .in_re(inRe),
      .in_im(inIm),
      .out_valid(outValid),
      .out_sop(outSop),
      .out_eop(outEop),
      .out_up_re(outUpRe),
      .out_up_im(outUpIm),
      .out_l_re(outLRe),
      .out_l_im(outLIm),
      .rom_16_counter(romCnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   // Frame-level model: once 32 samples are collected, the 16 pairs are scheduled from the next edge on.
   task automatic modelAccept(input sample_t re, input sample_t im, input bit sop, input int capEdge);
      pair_t p;
      int    start;
      if (sop) begin
         frameRe.delete();
         frameIm.delete();
      end
      frameRe.push_back(re);
      frameIm.push_back(im);
      if (frameRe.size() == 2*HALF) begin
         start = (capEdge + 1 > nextFree) ? capEdge + 1 : nextFree;
         for (int k = 0; k < HALF; k++) begin
            p.cyc  = start + k;
            p.k    = k;
            p.upRe = frameRe[k];
            p.upIm = frameIm[k];
            p.lRe  = frameRe[k+HALF];
            p.lIm  = frameIm[k+HALF];
            sbQ.push_back(p);
         end
         nextFree = start + HALF;
         frameRe.delete();
         frameIm.delete();
      end
   endtask

   task automatic applyStimulus(input bit v, input sample_t re, input sample_t im, input bit sop);
      inValid = v;
      inRe    = re;
      inIm    = im;
      inSop   = sop;
      if (v)
         modelAccept(re, im, sop, edgeCnt + 1);
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, '0, '0, 1'b0);
   endtask

   task automatic checkResetOutputs(input string name);
      checks++;
      if (outValid !== 1'b0 || outSop !== 1'b0 || outEop !== 1'b0 || outUpRe !== '0 || outUpIm !== '0 ||
          outLRe !== '0 || outLIm !== '0 || romCnt !== 4'd0) begin
         errors++;
         $display("[TB] FAIL %s: got valid=%0b sop=%0b eop=%0b up=(%0d,%0d) l=(%0d,%0d) rom=%0d, want all zero",
                  name, outValid, outSop, outEop, outUpRe, outUpIm, outLRe, outLIm, romCnt);
      end
   endtask

   // Called between edges; asserts reset asynchronously and expects outputs to clear right away.
   task automatic applyReset(input string name);
      inValid = 1'b0;
      inSop   = 1'b0;
      rst     = 1'b1;
      #1;
      checkResetOutputs(name);
      sbQ.delete();
      frameRe.delete();
      frameIm.delete();
      nextFree = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic checkOutput(input pair_t e);
      checks++;
      if (edgeCnt != e.cyc || outUpRe !== e.upRe || outUpIm !== e.upIm || outLRe !== e.lRe || outLIm !== e.lIm ||
          romCnt !== 4'(e.k) || outSop !== (e.k == 0) || outEop !== (e.k == HALF-1)) begin
         errors++;
         $display("[TB] FAIL pair k=%0d: got cyc=%0d up=(%0d,%0d) l=(%0d,%0d) rom=%0d sop=%0b eop=%0b; want cyc=%0d up=(%0d,%0d) l=(%0d,%0d) rom=%0d sop=%0b eop=%0b",
                  e.k, edgeCnt, outUpRe, outUpIm, outLRe, outLIm, romCnt, outSop, outEop,
                  e.cyc, e.upRe, e.upIm, e.lRe, e.lIm, e.k, (e.k == 0), (e.k == HALF-1));
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a pair, and checks quiet outputs otherwise.
   always @(negedge clk) begin
      if (!rst) begin
         while (sbQ.size() > 0 && sbQ[0].cyc < edgeCnt) begin
            checks++;
            errors++;
            $display("[TB] FAIL missingPair k=%0d: got no valid at cycle %0d, want valid (now cycle %0d)",
                     sbQ[0].k, sbQ[0].cyc, edgeCnt);
            void'(sbQ.pop_front());
         end
         if (outValid) begin
            if (sbQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpectedValid: got valid=1 rom=%0d at cycle %0d, want valid=0", romCnt, edgeCnt);
            end else begin
               monExp = sbQ.pop_front();
               checkOutput(monExp);
            end
         end else begin
            checkResetOutputs("idleOutputs");
         end
      end
   end

   task automatic sendRampFrame(input bit gapped);
      for (int n = 0; n < 2*HALF; n++) begin
         applyStimulus(1'b1, sample_t'(n), sample_t'(-n), 1'b0);
         if (gapped)
            applyStimulus(1'b0, sample_t'(511), sample_t'(511), 1'b0);
      end
   endtask

   task automatic sendRandomFrame(input bit withGaps);
      int sent;
      sent = 0;
      while (sent < 2*HALF) begin
         if (withGaps && $urandom_range(0, 2) == 0) begin
            applyStimulus(1'b0, sample_t'($urandom_range(0, 511)), sample_t'($urandom_range(0, 511)), 1'b0);
         end else begin
            applyStimulus(1'b1, sample_t'($urandom_range(0, 511)), sample_t'($urandom_range(0, 511)), 1'b0);
            sent++;
         end
      end
   endtask

   task automatic waitDrain(input string name);
      int budget;
      budget = 200;
      while (sbQ.size() > 0 && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      checks++;
      if (sbQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL %s: got %0d pairs still pending, want 0", name, sbQ.size());
         sbQ.delete();
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got simulation still running, want finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      @(posedge clk);
      #1;
      applyReset("powerOnReset");
      idleCycles(3);

      $display("[TB] single ramp frame");
      sendRampFrame(1'b0);
      idleCycles(20);
      waitDrain("drainRamp");

      $display("[TB] three back-to-back random frames");
      for (int f = 0; f < 3; f++)
         sendRandomFrame(1'b0);
      idleCycles(20);
      waitDrain("drainStream");

      $display("[TB] gapped ramp frame");
      sendRampFrame(1'b1);
      idleCycles(20);
      waitDrain("drainGapped");

      $display("[TB] extreme values");
      for (int n = 0; n < 2*HALF; n++)
         applyStimulus(1'b1, (n % 2) ? sample_t'(255) : sample_t'(-256), (n % 2) ? sample_t'(-256) : sample_t'(255), 1'b0);
      idleCycles(20);
      waitDrain("drainExtremes");

      $display("[TB] random frames with random gaps");
      for (int f = 0; f < 4; f++)
         sendRandomFrame(1'b1);
      idleCycles(20);
      waitDrain("drainRandomGaps");

      $display("[TB] reset mid-burst and mid-frame");
      sendRampFrame(1'b0);
      idleCycles(5);
      applyReset("resetMidBurst");
      for (int n = 0; n < 10; n++)
         applyStimulus(1'b1, sample_t'(77), sample_t'(-77), 1'b0);
      applyReset("resetMidFrame");
      sendRandomFrame(1'b0);
      idleCycles(20);
      waitDrain("drainAfterReset");

`ifdef FFT_IN_SOP_SYNC_EN
      $display("[TB] in_sop resynchronisation");
      for (int n = 0; n < 10; n++)
         applyStimulus(1'b1, sample_t'(-50 - n), sample_t'(50 + n), 1'b0);
      applyStimulus(1'b1, sample_t'(100), sample_t'(-100), 1'b1);
      for (int n = 1; n < 2*HALF; n++)
         applyStimulus(1'b1, sample_t'(n), sample_t'(-n), 1'b0);
      idleCycles(20);
      waitDrain("drainSopResync");
      applyStimulus(1'b1, sample_t'(123), sample_t'(-123), 1'b1);
      for (int n = 1; n < 2*HALF; n++)
         applyStimulus(1'b1, sample_t'(2*n), sample_t'(-2*n), 1'b0);
      idleCycles(20);
      waitDrain("drainSopAtZero");
`endif

      idleCycles(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
